// File: rtl/pc_fetch_pkg.sv
// pc_fetch shared encodings: next-PC select codes,
// fetch FSM states, reset PC and word-alignment helpers.
package pc_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] WORD_ZERO = '0;

  typedef enum logic [1:0] {
    NPC_PLUS4    = 2'd0,
    NPC_BRANCH   = 2'd1,
    NPC_JUMP_IMM = 2'd2,
    NPC_JUMP_REG = 2'd3
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic misaligned(
    input logic [XLEN-1:0] a
  );
    return |a[1:0];
  endfunction

endpackage

// File: rtl/pc_fetch_npc_calc.sv
// Combinational next-PC computation for the held
// instruction, plus a flag for a misaligned register target.
module npc_calc
  import pc_fetch_pkg::*;
(
  input  logic [XLEN-1:0] instr_pc,
  input  logic [1:0]      npc_op,
  input  logic [25:0]     imm,
  input  logic [XLEN-1:0] reg_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;

  assign pc4    = instr_pc + PC_STEP;
  assign br_off = {{14{imm[15]}}, imm[15:0], 2'b00};

  // Select the target for the resolved instruction
  always_comb begin
    next_pc  = pc4;
    misalign = 1'b0;
    unique case (npc_op_e'(npc_op))
      NPC_PLUS4:    next_pc = pc4;
      NPC_BRANCH:   next_pc = pc4 + br_off;
      NPC_JUMP_IMM: next_pc = {pc4[31:28], imm, 2'b00};
      NPC_JUMP_REG: begin
        next_pc  = word_align(reg_target);
        misalign = misaligned(reg_target);
      end
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: architectural PC, imem req/ack handshake,
// single-entry instruction buffer and redirect handling.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned ADDR_W   = XLEN
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              npc_valid,
  input  logic [1:0]        NPCOp,
  input  logic [25:0]       IMM,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              addr_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            ivalid_q, ivalid_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] next_pc;
  logic            npc_mis;
  logic [XLEN-1:0] redir_al;
  logic            redir_mis;

  npc_calc u_npc (
    .instr_pc   (ipc_q),
    .npc_op     (NPCOp),
    .imm        (IMM),
    .reg_target (RegTarget),
    .next_pc    (next_pc),
    .misalign   (npc_mis)
  );

  assign redir_al  = word_align(redirect_pc);
  assign redir_mis = misaligned(redirect_pc);

  // FSM next state, PC update and buffer capture
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    ivalid_d  = ivalid_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        if (redirect_valid) begin
          pc_d  = redir_al;
          err_d = redir_mis;
        end
      end
      ST_FETCH: begin
        if (!req_q) begin
          // gap cycle after a dropped fetch: re-request
          req_d = 1'b1;
          if (redirect_valid) begin
            pc_d  = redir_al;
            err_d = redir_mis;
          end
        end else if (imem_ack) begin
          req_d  = 1'b0;
          pend_d = 1'b0;
          if (redirect_valid) begin
            pc_d  = redir_al;
            err_d = redir_mis;
          end else if (pend_q) begin
            pc_d = pend_pc_q;
          end else begin
            instr_d  = imem_rdata;
            ipc_d    = pc_q;
            ivalid_d = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // keep the handshake; apply target on ack
          pend_d    = 1'b1;
          pend_pc_d = redir_al;
          err_d     = redir_mis;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d     = redir_al;
          err_d    = redir_mis;
          ivalid_d = 1'b0;
          req_d    = 1'b1;
          state_d  = ST_FETCH;
        end else if (npc_valid) begin
          pc_d     = next_pc;
          err_d    = npc_mis;
          ivalid_d = 1'b0;
          req_d    = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      instr_q   <= WORD_ZERO;
      ipc_q     <= WORD_ZERO;
      ivalid_q  <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= WORD_ZERO;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      ivalid_q  <= ivalid_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      err_q     <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = ivalid_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: target table,
// hand sequences for redirect/reset, random model run.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        npc_valid;
  logic [1:0]  NPCOp;
  logic [25:0] IMM;
  logic [31:0] RegTarget;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        addr_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .npc_valid      (npc_valid),
    .NPCOp          (NPCOp),
    .IMM            (IMM),
    .RegTarget      (RegTarget),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .addr_err       (addr_err)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic [1:0]  op;
    logic [25:0] imm;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // wait (bounded) for req, check address, ack after wait_n
  task automatic serve(input int wait_n,
                       input logic [31:0] exp_addr,
                       input logic [31:0] data,
                       input bit noise);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("req_seen", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, exp_addr);
    for (int w = 0; w < wait_n; w++) begin
      npc_valid = noise ? 1'($urandom % 2) : 1'b0;
      NPCOp = 2'($urandom % 4);
      tick();
    end
    npc_valid  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    chk1("instr_valid", instr_valid, 1'b1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, exp_addr);
  endtask

  task automatic redirect_from_hold(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc = p;
    tick();
    redirect_valid = 1'b0;
  endtask

  // reference: next-PC from the architectural rules
  function automatic logic [31:0] ref_next(
    input logic [31:0] pc, input logic [1:0] op,
    input logic [25:0] imm, input logic [31:0] rt);
    logic [31:0] off;
    off = 32'(int'($signed(imm[15:0])) * 4);
    case (op)
      2'd0: return pc + 32'd4;
      2'd1: return pc + 32'd4 + off;
      2'd2: return ((pc + 32'd4) & 32'hF000_0000)
                   | (32'(imm) * 32'd4);
      default: return rt & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    logic [31:0] cur, nxt, d;
    logic        e;
    tbl[0] = '{32'h3000, 2'd0, 26'h0, 32'h0,
               32'h3004, 1'b0};
    tbl[1] = '{32'h3010, 2'd1, 26'h000FFFE, 32'h0,
               32'h300C, 1'b0};
    tbl[2] = '{32'h3010, 2'd1, 26'h0000003, 32'h0,
               32'h3020, 1'b0};
    tbl[3] = '{32'h3000, 2'd2, 26'h0000C08, 32'h0,
               32'h3020, 1'b0};
    tbl[4] = '{32'h3000, 2'd3, 26'h0, 32'h0040_0006,
               32'h0040_0004, 1'b1};
    tbl[5] = '{32'hFFFF_FFFC, 2'd0, 26'h0, 32'h0,
               32'h0, 1'b0};
    tbl[6] = '{32'hF000_0000, 2'd2, 26'h3FF_FFFF, 32'h0,
               32'hFFFF_FFFC, 1'b0};
    tbl[7] = '{32'h0, 2'd1, 26'h0008000, 32'h0,
               32'hFFFE_0004, 1'b0};
    tbl[8] = '{32'h3000, 2'd3, 26'h0, 32'h1234_5678,
               32'h1234_5678, 1'b0};

    rstn = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    npc_valid = 1'b0;
    NPCOp = '0;
    IMM = '0;
    RegTarget = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // reset values
    tick();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_ivalid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk1("rst_err", addr_err, 1'b0);
    rstn = 1'b1;

    // first fetch, zero-wait memory, then PLUS4
    serve(0, 32'h3000, 32'h2008_0005, 1'b0);
    chk1("hold_req_low", imem_req, 1'b0);
    NPCOp = 2'd0;
    npc_valid = 1'b1;
    tick();
    npc_valid = 1'b0;
    chk1("plus4_req", imem_req, 1'b1);
    chk("plus4_addr", imem_addr, 32'h3004);
    serve(0, 32'h3004, 32'h1111_0000, 1'b0);

    // target table
    foreach (tbl[i]) begin
      redirect_from_hold(tbl[i].start_pc);
      serve(0, tbl[i].start_pc, $urandom, 1'b0);
      NPCOp = tbl[i].op;
      IMM = tbl[i].imm;
      RegTarget = tbl[i].rt;
      npc_valid = 1'b1;
      tick();
      npc_valid = 1'b0;
      chk1("tbl_err", addr_err, tbl[i].exp_err);
      chk("tbl_next", imem_addr, tbl[i].exp_pc);
      serve(0, tbl[i].exp_pc, $urandom, 1'b0);
      chk1("tbl_err_pulse", addr_err, 1'b0);
    end

    // redirect during a slow fetch
    redirect_from_hold(32'h3100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0180;
    tick();
    redirect_valid = 1'b0;
    chk1("pend_req1", imem_req, 1'b1);
    chk("pend_addr1", imem_addr, 32'h3100);
    tick();
    chk1("pend_req2", imem_req, 1'b1);
    chk("pend_addr2", imem_addr, 32'h3100);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk1("pend_drop", instr_valid, 1'b0);
    chk1("pend_gap", imem_req, 1'b0);
    tick();
    chk1("pend_rereq", imem_req, 1'b1);
    chk("pend_new", imem_addr, 32'h8000_0180);
    serve(0, 32'h8000_0180, 32'hA5A5_0001, 1'b0);

    // last redirect wins; misaligned; npc ignored
    redirect_from_hold(32'h3100);
    redirect_from_hold(32'h5000);
    redirect_valid = 1'b1;
    redirect_pc = 32'h6002;
    npc_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk1("ovw_err", addr_err, 1'b1);
    chk("ovw_old", imem_addr, 32'h3100);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    npc_valid = 1'b0;
    chk1("ovw_err_pulse", addr_err, 1'b0);
    chk1("ovw_drop", instr_valid, 1'b0);
    tick();
    chk("ovw_new", imem_addr, 32'h6000);
    serve(0, 32'h6000, 32'h0000_6000, 1'b0);

    // redirect beats branch in HOLD
    redirect_valid = 1'b1;
    redirect_pc = 32'h3200;
    npc_valid = 1'b1;
    NPCOp = 2'd1;
    IMM = 26'h3;
    tick();
    redirect_valid = 1'b0;
    npc_valid = 1'b0;
    chk("redir_prio", imem_addr, 32'h3200);
    serve(0, 32'h3200, 32'h0000_3200, 1'b0);

    // reset while a fetch is outstanding
    redirect_from_hold(32'h3400);
    tick();
    rstn = 1'b0;
    tick();
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_iv", instr_valid, 1'b0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_ipc", instr_pc, 32'h0);
    rstn = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk1("late_ack_iv", instr_valid, 1'b0);
    chk("restart_addr", imem_addr, 32'h3000);
    serve(0, 32'h3000, 32'h2008_0005, 1'b0);

    // random run against the reference model
    cur = 32'h3000;
    for (int it = 0; it < 150; it++) begin
      int k;
      k = $urandom % 3;
      for (int h = 0; h < k; h++) begin
        imem_ack = 1'($urandom % 2);
        tick();
      end
      imem_ack = 1'b0;
      if ($urandom % 8 == 0) begin
        redirect_pc = $urandom;
        nxt = redirect_pc & 32'hFFFF_FFFC;
        e = (redirect_pc % 4) != 0;
        redirect_valid = 1'b1;
        npc_valid = 1'($urandom % 2);
      end else begin
        NPCOp = 2'($urandom % 4);
        IMM = 26'($urandom);
        RegTarget = $urandom;
        nxt = ref_next(cur, NPCOp, IMM, RegTarget);
        e = (NPCOp == 2'd3) && (RegTarget % 4 != 0);
        npc_valid = 1'b1;
      end
      tick();
      redirect_valid = 1'b0;
      npc_valid = 1'b0;
      chk1("rnd_err", addr_err, e);
      d = $urandom;
      serve(int'($urandom % 4), nxt, d, 1'b1);
      cur = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
